vga_sync_gen: RTL

- Timing stage around the horizontal and vertical pixel counters in the Pong video path.
- Generates the pixel-rate enable that steps the horizontal counter.
- Generates the vertical-counter enable at end of line.
- Decodes the incoming h/v counts into registered hsync, vsync, video_on and pixel coordinates for the ball/paddle renderer, plus line-end and frame-end strobes for game-logic update.

---
 rtl/vga_timing_pkg.sv | 32 +++
 rtl/pixel_tick_div.sv | 33 +++
 rtl/vga_sync_gen.sv | 109 ++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared 640x480@60 timing constants for the Pong video path, plus the
//   decoded-sync bundle produced by vga_sync_gen each clock.
//   No ports (package).
package vga_timing_pkg;

    localparam int H_VIS  = 640;
    localparam int H_FP   = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;
    localparam int V_VIS  = 480;
    localparam int V_FP   = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 33;

    localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;   // 800
    localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;   // 525
    localparam int HS_START = H_VIS + H_FP;                   // 656
    localparam int HS_END   = HS_START + H_SYNC - 1;          // 751
    localparam int VS_START = V_VIS + V_FP;                   // 490
    localparam int VS_END   = VS_START + V_SYNC - 1;          // 491

    // Next-state bundle for the registered decode outputs.
    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       video_on;
        logic [9:0] x;
        logic [9:0] y;
    } sync_dec_t;

endpackage

// File: rtl/pixel_tick_div.sv
// pixel_tick_div
//   Divides the system clock down to a one-clock pixel-rate tick.
//   Ports:
//     clk   in  system clock
//     rst   in  asynchronous active-high reset
//     tick  out registered pulse, high for one clk every DIV clks; the first
//               pulse appears DIV clks after reset release
module pixel_tick_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt;

    // tick is registered from the terminal count, so it lags the counter by
    // one clk: count 0..DIV-1 after release puts the first tick at clk DIV.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick    <= (div_cnt == LAST);
            div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//   Timing stage around the external horizontal/vertical pixel counters.
//   Produces the pixel-rate enable for the h counter, the end-of-line enable
//   for the v counter, and a 1-clk-latency registered decode of the counts.
//   Ports:
//     clk        in   system clock
//     rst        in   asynchronous active-high reset
//     h_count    in   current horizontal count
//     v_count    in   current vertical count
//     pix_en     out  one-clk pulse every DIV clks (h counter enable)
//     v_en       out  combinational pix_en & last h (v counter enable)
//     hsync      out  registered horizontal sync, active level SYNC_ACT
//     vsync      out  registered vertical sync, active level SYNC_ACT
//     video_on   out  registered, high inside the visible area
//     x, y       out  registered pixel coordinates, 0 when blanked
//     line_end   out  registered strobe, last pixel of a line
//     frame_end  out  registered strobe, last pixel of the last line
module vga_sync_gen #(
    parameter int   DIV      = 4,
    parameter int   H_VIS    = vga_timing_pkg::H_VIS,
    parameter int   H_FP     = vga_timing_pkg::H_FP,
    parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int   H_BP     = vga_timing_pkg::H_BP,
    parameter int   V_VIS    = vga_timing_pkg::V_VIS,
    parameter int   V_FP     = vga_timing_pkg::V_FP,
    parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int   V_BP     = vga_timing_pkg::V_BP,
    parameter logic SYNC_ACT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] h_count,
    input  logic [9:0] v_count,
    output logic       pix_en,
    output logic       v_en,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_end,
    output logic       frame_end
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VISC = 10'(H_VIS);
    localparam logic [9:0] V_VISC = 10'(V_VIS);
    localparam logic [9:0] HS_LO  = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_HI  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_LO  = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_HI  = 10'(V_VIS + V_FP + V_SYNC - 1);

    vga_timing_pkg::sync_dec_t dec_d;

    logic h_last;
    logic v_last;
    logic in_range;

    pixel_tick_div #(.DIV(DIV)) u_div (
        .clk  (clk),
        .rst  (rst),
        .tick (pix_en)
    );

    assign h_last   = (h_count == H_LAST);
    assign v_last   = (v_count == V_LAST);
    // Counts past the frame end (e.g. a glitched counter) decode as fully
    // blanked with syncs idle, so the monitor never sees a bogus sync.
    assign in_range = (h_count <= H_LAST) && (v_count <= V_LAST);

    // Left combinational so the v counter steps on the same edge as the h wrap.
    assign v_en = pix_en && h_last;

    always_comb begin
        dec_d          = '0;
        dec_d.hsync    = (in_range && h_count >= HS_LO && h_count <= HS_HI) ? SYNC_ACT : ~SYNC_ACT;
        dec_d.vsync    = (in_range && v_count >= VS_LO && v_count <= VS_HI) ? SYNC_ACT : ~SYNC_ACT;
        dec_d.video_on = (h_count < H_VISC) && (v_count < V_VISC);
        if (dec_d.video_on) begin
            dec_d.x = h_count;
            dec_d.y = v_count;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync     <= ~SYNC_ACT;
            vsync     <= ~SYNC_ACT;
            video_on  <= 1'b0;
            x         <= '0;
            y         <= '0;
            line_end  <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            hsync     <= dec_d.hsync;
            vsync     <= dec_d.vsync;
            video_on  <= dec_d.video_on;
            x         <= dec_d.x;
            y         <= dec_d.y;
            line_end  <= pix_en && h_last && (v_count <= V_LAST);
            frame_end <= pix_en && h_last && v_last;
        end
    end

endmodule
